req_ack_tx: RTL
===============

# req_ack_tx

Parametrised transmit side of the single-word request/acknowledge link used between our driver/receiver pairs. Accepts words on a valid/ready push port, buffers them in a small FIFO, and sends each one across the link with a selectable 2-phase or 4-phase handshake. The incoming acknowledge passes through a configurable synchroniser, so the far receiver may run on an unrelated clock. Adds a sent-word counter and a sticky acknowledge-timeout flag.

## Interface
- DW, 4, data word width (1..32)
- DEPTH, 4, FIFO depth in words (power of two, 2..16)
- PHASES, 4, handshake protocol: 4 = return-to-zero, 2 = transition signalling
- SYNC_STAGES, 2, flip-flop stages on data_ack (0 = no synchroniser, max 3)
- TIMEOUT, 255, cycles waiting for an ack edge before ack_timeout sets (1..65535)

Ports:
- clk_a  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  push request
- in_data  input  DW  push word
- in_ready  output  1  FIFO can accept a word
- data  output  DW  link data, held stable while a transfer is open
- data_req  output  1  link request
- data_ack  input  1  link acknowledge, asynchronous to clk_a
- busy  output  1  FSM not in IDLE or FIFO not empty
- sent_cnt  output  16  completed transfers, wraps at 65535->0
- ack_timeout  output  1  sticky; set on timeout, cleared only by rst

## Operation
- Reset values: in_ready=1 (combinational from count), data=0, data_req=0, busy=0, sent_cnt=0, ack_timeout=0. FIFO flushed, synchroniser cleared, FSM in IDLE, timer 0.
- FIFO: push on in_valid&in_ready. in_ready = (count<DEPTH) and never depends on a same-cycle pop. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- ack_s is data_ack delayed by SYNC_STAGES flops. With SYNC_STAGES=0, ack_s = data_ack.
- FSM for PHASES=4:
  - IDLE: if FIFO is non-empty, pop, load data, set data_req=1, go to REQ.
  - REQ: on ack_s=1, set data_req=0, increment sent_cnt, go to RELEASE.
  - RELEASE: on ack_s=0, go to IDLE.
- FSM for PHASES=2:
  - IDLE: if FIFO is non-empty, pop, load data, toggle data_req, go to REQ.
  - REQ: on ack_s==data_req, increment sent_cnt, go to IDLE. RELEASE is unused.
- data changes only on the pop edge. It holds its value in IDLE.
- Timer: cleared on every state entry and counts cycles spent in REQ or RELEASE. When it reaches TIMEOUT, ack_timeout sets. The timer saturates and the FSM keeps waiting (no abort, no retry).
- A push arriving while the FSM is in REQ or RELEASE is buffered. Order is strictly FIFO.
- rst asserted mid-transfer: all state returns to reset values on that edge. Any word in flight is dropped and not counted.

## Timing
- Word pushed at edge k into an empty FIFO with FSM in IDLE: popped at edge k+1, so data and data_req change after edge k+1. Latency is 1 cycle.
- ack_s sees a data_ack change SYNC_STAGES edges after it is sampled.
- In 4-phase mode, data_req falls on the first edge where ack_s=1. sent_cnt increments on that same edge.
- In 4-phase mode, the minimum transfer period is 3 + 2*SYNC_STAGES cycles, plus receiver delay. There is one mandatory IDLE cycle between transfers.
- In 2-phase mode, the minimum period is 2 + SYNC_STAGES cycles.
- busy falls on the edge the FSM enters IDLE with the FIFO empty.

## Test plan
- Reset with ack held 0: after rst, data_req=0, in_ready=1, sent_cnt=0, busy=0. Drive rst=1 with in_valid=1: no push is accepted.
- 4-phase, DW=4, SYNC_STAGES=2: push 0x3, 0xA, 0x5 back-to-back; receiver on a 2x-period clock acks each. Required: data shows 3, A, 5 in order; each data_req falls 2 cycles after ack rises; sent_cnt=3; busy=0 at the end.
- Full FIFO, DEPTH=4, ack held 0: push 6 words. Required: 5 accepted (1 popped, 4 buffered); in_ready=0 from then on; the remaining 4 words are delivered in order once ack toggles.
- PHASES=2: push 0x1, 0x2. Required: data_req goes 0->1->0 with data 1, then 2; each sent_cnt increment occurs SYNC_STAGES cycles after the ack edge matching the req level.
- Timeout, TIMEOUT=10: push one word and never ack. Required: ack_timeout=1 exactly 10 cycles after REQ entry and stays 1; a late ack still completes the transfer with sent_cnt=1.
- rst during REQ with 2 words buffered: all outputs return to reset values on that edge, and sent_cnt is unchanged from 0.

Source files
------------

// File: rtl/req_ack_tx_if.sv
// Push port and request/acknowledge link of the req_ack_tx transmitter.
// master is the transmitter side, slave is the producer/receiver side.
interface req_ack_tx_if #(
    parameter int DW = 4
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [DW-1:0] data;
    logic          data_req;
    logic          data_ack;

    modport master (
        input  in_valid,
        input  in_data,
        input  data_ack,
        output in_ready,
        output data,
        output data_req
    );

    modport slave (
        output in_valid,
        output in_data,
        output data_ack,
        input  in_ready,
        input  data,
        input  data_req
    );
endinterface

// File: rtl/req_ack_tx.sv
// Transmit side of the request/acknowledge link: push FIFO, ack synchroniser,
// 2-phase or 4-phase handshake FSM, sent-word counter and sticky ack timeout.
module req_ack_tx #(
    parameter int DW          = 4,
    parameter int DEPTH       = 4,
    parameter int PHASES      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic         clk_a,
    input  logic         rst,
    req_ack_tx_if.master link,
    output logic         busy,
    output logic [15:0]  sent_cnt,
    output logic         ack_timeout
);
    localparam int              PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW        = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_V   = CW'(DEPTH);
    localparam logic [15:0]     TIMEOUT_V = 16'(TIMEOUT);
    localparam bit              TWO_PHASE = (PHASES == 2);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e        state_q;
    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [DW-1:0] data_q;
    logic          req_q;
    logic [15:0]   cnt_q;
    logic [15:0]   timer_q;
    logic          timeout_q;
    logic          busy_q;

    logic          ack_s;
    logic          push_s;
    logic          pop_s;
    logic          ack_done_s;

    // in_ready looks only at the registered count, never at a same-cycle pop
    assign link.in_ready = (count_q < DEPTH_V);
    assign push_s        = link.in_valid && link.in_ready;
    assign pop_s         = (state_q == ST_IDLE) && (count_q != '0);
    assign ack_done_s    = TWO_PHASE ? (ack_s == req_q) : ack_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign ack_s = link.data_ack;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            // acknowledge synchroniser chain
            always_ff @(posedge clk_a) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= link.data_ack;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign ack_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // FIFO occupancy after this cycle's push and pop
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage
    always_ff @(posedge clk_a) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= link.in_data;
        end
    end

    // FIFO pointers and count
    always_ff @(posedge clk_a) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    // handshake FSM with registered link outputs, counter, timer and busy
    always_ff @(posedge clk_a) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            req_q     <= 1'b0;
            cnt_q     <= 16'd0;
            timer_q   <= 16'd0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    timer_q <= 16'd0;
                    if (pop_s) begin
                        data_q  <= mem_q[rd_ptr_q];
                        req_q   <= TWO_PHASE ? ~req_q : 1'b1;
                        state_q <= ST_REQ;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= (count_d != '0);
                    end
                end
                ST_REQ: begin
                    if (ack_done_s) begin
                        cnt_q   <= cnt_q + 16'd1;
                        timer_q <= 16'd0;
                        if (TWO_PHASE) begin
                            state_q <= ST_IDLE;
                            busy_q  <= (count_d != '0);
                        end else begin
                            req_q   <= 1'b0;
                            state_q <= ST_RELEASE;
                            busy_q  <= 1'b1;
                        end
                    end else if (timer_q != TIMEOUT_V) begin
                        // timer saturates at TIMEOUT; the flag is raised on the reaching edge
                        timer_q <= timer_q + 16'd1;
                        if (timer_q == TIMEOUT_V - 16'd1) begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (!ack_s) begin
                        state_q <= ST_IDLE;
                        timer_q <= 16'd0;
                        busy_q  <= (count_d != '0);
                    end else if (timer_q != TIMEOUT_V) begin
                        timer_q <= timer_q + 16'd1;
                        if (timer_q == TIMEOUT_V - 16'd1) begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    timer_q <= 16'd0;
                    req_q   <= 1'b0;
                    busy_q  <= (count_d != '0);
                end
            endcase
        end
    end

    assign link.data     = data_q;
    assign link.data_req = req_q;
    assign busy          = busy_q;
    assign sent_cnt      = cnt_q;
    assign ack_timeout   = timeout_q;
endmodule
